// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer.
// Holds the sequencer state encoding, the default cycle and width constants,
// and the Moore output decode shared by the top level.
package pll_seq_pkg;

  // Sequencer states; encoding is fixed and visible on debug taps.
  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Defaults sized for a 74.25 MHz reference clock.
  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 1048576;
  localparam int unsigned DEF_MAX_RETRIES         = 7;
  localparam int unsigned DEF_CNT_W               = 21;
  localparam int unsigned DEF_RTY_W               = 3;

  // Level outputs that are a pure function of the sequencer state.
  typedef struct packed {
    logic pll_rst;
    logic core_reset;
    logic ready;
    logic fail;
  } seq_out_t;

  // Moore decode; applied to the next state so the registered outputs
  // line up with the state register.
  function automatic seq_out_t decode_state(input state_t st);
    seq_out_t o;
    o.pll_rst    = (st == ST_RESET_PLL) || (st == ST_FAIL);
    o.core_reset = (st != ST_RUN);
    o.ready      = (st == ST_RUN);
    o.fail       = (st == ST_FAIL);
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset to 0.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears both flops
//   d    - asynchronous input bit
//   q    - d resynchronized to clk, two cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock handshake initiator.
// Pulses the PLL reset, waits for lock with a timeout and bounded retries,
// qualifies the lock for a number of consecutive cycles, then releases the
// core reset. Loss of lock at run time restarts the whole sequence.
// Ports:
//   refclk       - board reference clock, valid before the PLL locks
//   rst          - synchronous active-high reset
//   pll_locked   - PLL lock flag, asynchronous to refclk
//   relock_req   - one-cycle request to rerun the sequence (RUN / FAIL only)
//   pll_rst      - reset to the PLL
//   core_reset   - reset for logic clocked from the PLL outputs
//   ready        - lock present and qualified
//   fail         - all retries exhausted
//   lost_lock    - one-cycle pulse when lock drops while running
//   retry_count  - retries used in the current sequence
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W,
  parameter int unsigned RTY_W               = DEF_RTY_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             core_reset,
  output logic             ready,
  output logic             fail,
  output logic             lost_lock,
  output logic [RTY_W-1:0] retry_count
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_ONE     = RTY_W'(1);
  localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_d;
  logic             lost_d;
  logic             locked_s;
  seq_out_t         out_d;

  // Lock flag crosses into refclk; only the synchronized copy is used.
  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state, shared counter and retry bookkeeping.
  // cnt is cleared on every state change, so it never needs to wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_count;
    lost_d  = 1'b0;

    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT_LOCK: begin
        if (locked_s) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d = '0;
          if (retry_count == RTY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_count + RTY_ONE;
            state_d = ST_RESET_PLL;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A dropout during qualification goes back to waiting without
      // spending a retry; the timeout window starts over.
      ST_STABLE: begin
        if (!locked_s) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_d   = '0;
          retry_d = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Lock loss wins over a simultaneous relock request.
      ST_RUN: begin
        if (!locked_s) begin
          cnt_d   = '0;
          lost_d  = 1'b1;
          state_d = ST_RESET_PLL;
        end else if (relock_req) begin
          cnt_d   = '0;
          state_d = ST_RESET_PLL;
        end
      end

      ST_FAIL: begin
        if (relock_req) begin
          cnt_d   = '0;
          retry_d = '0;
          state_d = ST_RESET_PLL;
        end
      end

      default: begin
        cnt_d   = '0;
        retry_d = '0;
        state_d = ST_RESET_PLL;
      end
    endcase

    out_d = decode_state(state_d);
  end

  // State, counter and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      core_reset  <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
      lost_lock   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_count <= retry_d;
      pll_rst     <= out_d.pll_rst;
      core_reset  <= out_d.core_reset;
      ready       <= out_d.ready;
      fail        <= out_d.fail;
      lost_lock   <= lost_d;
    end
  end

endmodule
